// File: rtl/serial_sub_restorer_pkg.sv
// Shared constants and state encoding for the bit-serial minuend restorer.
// Imported by the restorer top level.
package serial_sub_restorer_pkg;

  localparam int W_DEF = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT,
    ST_DONE  = DONE
  } state_t;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W_DEF = cnt_width(W_DEF);

endpackage

// File: rtl/FullAdder.sv
// Single-bit full adder shared across the team's arithmetic blocks.
// Purely combinational.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_sub_restorer.sv
// Rebuilds X = D + Y + ~C_i one bit per clock, LSB first, using one
// full adder and a start/busy/done handshake.
module serial_sub_restorer
  import serial_sub_restorer_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] D,
  input  logic [W-1:0] Y,
  input  logic         C_i,
  output logic [W-1:0] X,
  output logic         C_r,
  output logic         busy,
  output logic         done
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state;
  logic [W-1:0]  sh_d;
  logic [W-1:0]  sh_y;
  logic [W-1:0]  sh_r;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          sum;
  logic          cout;

  FullAdder u_fa (
    .a   (sh_d[0]),
    .b   (sh_y[0]),
    .cin (carry),
    .sum (sum),
    .cout(cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sh_d  <= '0;
      sh_y  <= '0;
      sh_r  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      X     <= '0;
      C_r   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sh_d  <= D;
            sh_y  <= Y;
            carry <= ~C_i;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sh_d  <= sh_d >> 1;
          sh_y  <= sh_y >> 1;
          sh_r  <= {sum, sh_r[W-1:1]};
          carry <= cout;
          cnt   <= cnt + 1'b1;
          // Outputs load only on the final bit so X never shows partials.
          if (cnt == LAST) begin
            X     <= {sum, sh_r[W-1:1]};
            C_r   <= cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_restorer.sv
// Directed bench for serial_sub_restorer: timing, vectors, exhaustive
// round trip, held start, mid-op reset and reset/start collision.
module tb_serial_sub_restorer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] D;
  logic [W-1:0] Y;
  logic         C_i;
  logic [W-1:0] X;
  logic         C_r;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_sub_restorer #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .D    (D),
    .Y    (Y),
    .C_i  (C_i),
    .X    (X),
    .C_r  (C_r),
    .busy (busy),
    .done (done)
  );

  // lat = edges from accept to done; -1 when done never shows.
  task automatic run_op(
    input  logic [W-1:0] d,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] x,
    output logic         cr,
    output int           lat
  );
    @(negedge clk);
    D = d; Y = y; C_i = ci; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < W + 4) begin
      @(negedge clk);
      lat++;
    end
    x  = X;
    cr = C_r;
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    D = '0; Y = '0; C_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (X !== 4'h0 || C_r !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: X=%h C_r=%b want 0 0", X, C_r);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: busy=%b done=%b want 0 0", busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    D = 4'h9; Y = 4'h3; C_i = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL basic_busy[%0d]: busy=%b done=%b want 1 0",
                 k, busy, done);
      end
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || X !== 4'hC || C_r !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: done=%b busy=%b X=%h C_r=%b want 1 0 c 0",
               done, busy, X, C_r);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || X !== 4'hC) begin
      bad++;
      $display("FAIL basic_pulse: done=%b X=%h want 0 c", done, X);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] vd [2];
    logic [W-1:0] vy [2];
    logic         vc [2];
    logic [W-1:0] ex [2];
    logic         ec [2];
    logic [W-1:0] x;
    logic         cr;
    int           lat;
    vd[0] = 4'h8; vy[0] = 4'h3; vc[0] = 1'b0; ex[0] = 4'hC; ec[0] = 1'b0;
    vd[1] = 4'hF; vy[1] = 4'h1; vc[1] = 1'b1; ex[1] = 4'h0; ec[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_op(vd[i], vy[i], vc[i], x, cr, lat);
      total++;
      if (lat !== W || x !== ex[i] || cr !== ec[i]) begin
        bad++;
        $display("FAIL vector[%0d]: lat=%0d X=%h C_r=%b want %0d %h %b",
                 i, lat, x, cr, W, ex[i], ec[i]);
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [W-1:0] d;
    logic [W:0]   full;
    logic [W-1:0] xi;
    logic [W-1:0] yi;
    logic [W-1:0] x;
    logic         cr;
    int           lat;
    for (int xv = 0; xv < 16; xv++) begin
      for (int yv = 0; yv < 16; yv++) begin
        for (int c = 0; c < 2; c++) begin
          xi = W'(xv);
          yi = W'(yv);
          d = xi + ~yi + W'(c);
          full = {1'b0, d} + {1'b0, yi} + (W+1)'(c == 0);
          run_op(d, yi, c[0], x, cr, lat);
          total++;
          if (lat !== W || x !== xi || cr !== full[W]) begin
            bad++;
            $display("FAIL roundtrip x=%h y=%h ci=%0d: X=%h C_r=%b lat=%0d want %h %b %0d",
                     xi, yi, c, x, cr, lat, xi, full[W], W);
          end
        end
      end
    end
  endtask

  task automatic test_start_held();
    int gap;
    @(negedge clk);
    D = 4'h9; Y = 4'h3; C_i = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    D = 4'h2; Y = 4'h5; C_i = 1'b0;
    gap = 0;
    while (done !== 1'b1 && gap < W + 4) begin
      @(negedge clk);
      gap++;
    end
    total++;
    if (done !== 1'b1 || X !== 4'hC) begin
      bad++;
      $display("FAIL held_first: done=%b X=%h want 1 c", done, X);
    end
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (done !== 1'b1 && gap < W + 8);
    start = 1'b0;
    total++;
    if (gap !== W + 2 || X !== 4'h8) begin
      bad++;
      $display("FAIL held_second: gap=%0d X=%h want %0d 8", gap, X, W + 2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] x;
    logic         cr;
    int           lat;
    @(negedge clk);
    D = 4'hF; Y = 4'h1; C_i = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || X !== 4'h0 || C_r !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: busy=%b done=%b X=%h C_r=%b want 0 0 0 0",
               busy, done, X, C_r);
    end
    repeat (W + 1) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_idle: busy=%b done=%b want 0 0", busy, done);
    end
    run_op(4'h8, 4'h3, 1'b0, x, cr, lat);
    total++;
    if (lat !== W || x !== 4'hC || cr !== 1'b0) begin
      bad++;
      $display("FAIL mid_after: lat=%0d X=%h C_r=%b want %0d c 0",
               lat, x, cr, W);
    end
  endtask

  task automatic test_rst_start();
    int lat;
    @(negedge clk);
    D = 4'h9; Y = 4'h3; C_i = 1'b1;
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || X !== 4'h0) begin
      bad++;
      $display("FAIL rst_start_idle: busy=%b X=%h want 0 0", busy, X);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_start_accept: busy=%b want 1", busy);
    end
    lat = 0;
    while (done !== 1'b1 && lat < W + 4) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (done !== 1'b1 || X !== 4'hC || C_r !== 1'b0) begin
      bad++;
      $display("FAIL rst_start_result: done=%b X=%h C_r=%b want 1 c 0",
               done, X, C_r);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_roundtrip();
    test_start_held();
    test_reset_mid();
    test_rst_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sub_restorer.md
# serial_sub_restorer

Bit-serial inverse of the team's 4-bit ripple subtractor (X + ~Y + C_i). Given a subtractor result D, the subtrahend Y and the carry-in C_i used, it rebuilds the minuend X = D + Y + ~C_i (mod 2^W) one bit per clock, LSB first. It sits downstream of the subtractor in the datapath and runs under a start/busy/done handshake. Its purpose is round-trip checking and operand recovery without a second parallel adder.

## Interface
- W, 4, operand width in bits (legal range 2..16)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- D  input  W  subtractor result to undo; captured on accepted start
- Y  input  W  subtrahend; captured on accepted start
- C_i  input  1  carry-in the subtractor used; captured on accepted start
- X  output  W  reconstructed minuend; valid while done=1 and held until the next accepted start
- C_r  output  1  carry out of the MSB of the reconstruction addition
- busy  output  1  high in SHIFT
- done  output  1  one-cycle pulse, high in DONE

## Operation
- States:
  - IDLE: on start=1, load D and Y into shift registers, load the carry flop with ~C_i, clear the bit counter, go to SHIFT.
  - SHIFT: each cycle a full adder sums shD[0] + shY[0] + carry.
    - Shift the sum bit into the MSB of the result register; the result register shifts right.
    - Shift shD and shY right.
    - Carry flop takes the adder carry.
    - Counter increments.
    - After bit W-1 is processed, go to DONE.
  - DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- Arithmetic: X = (D + Y + ~C_i) mod 2^W. C_r = bit W of the same sum. For every X, Y, C_i, the round trip subtract-then-restore returns X.
- start in SHIFT or DONE is ignored and not queued. D, Y and C_i changing after capture have no effect.
- X and C_r update only on the edge that enters DONE. They are not written during SHIFT, so X never shows partial sums.
- Reset, including mid-operation: state=IDLE, X=0, C_r=0, busy=0, done=0, shift registers, counter and carry flop all cleared. Any operation in progress is discarded.
- rst and start asserted in the same cycle: reset wins.

## Timing
- start accepted at edge t:
  - busy=1 after edges t .. t+W-1.
  - Bit k is processed at edge t+1+k.
  - At edge t+W the state enters DONE; X, C_r and done=1 are visible after t+W.
- At edge t+W+1 the state returns to IDLE and done falls.
- Latency from start edge to done is W cycles. Throughput is one operation per W+2 cycles, since back-to-back starts are accepted only in IDLE.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package holds:
  - the W default constant;
  - the state encoding as localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - a counter-width constant (ceil log2 W).
- The per-bit adder instantiates the team's existing single-bit `FullAdder` module as its one sub-module. No new adder is written.
- Top level contains:
  - the FSM;
  - the three W-bit shift registers (D, Y, result);
  - the carry flop and bit counter;
  - the output registers.

## Test plan
- D=4'h9, Y=4'h3, C_i=1, start pulse → busy for 4 cycles; done after 4 cycles with X=4'hC, C_r=0.
- D=4'h8, Y=4'h3, C_i=0 → X=4'hC, C_r=0. D=4'hF, Y=4'h1, C_i=1 → X=4'h0, C_r=1 (wrap).
- Exhaustive round trip over all 512 (X, Y, C_i): feed the subtractor, then this block; X out equals X in for every case, one start per IDLE.
- start held high through an operation with D and Y changed mid-SHIFT → result uses the first captured operands. A second operation begins only after DONE→IDLE, so done pulses once per W+2 cycles.
- rst asserted in the cycle after bit 1 is processed → the next cycle shows IDLE, busy=0, done=0, X=0, C_r=0. A subsequent start yields a correct result.
- rst and start high together in IDLE → remains IDLE with no busy. start alone on the next cycle is accepted normally.
